// File: rtl/mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_sequencer                                                              |
// | Load/store bus initiator: fetches 3-byte instructions, one access per op.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h8000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fbo,
  output logic [15:0] abi,
  output logic [7:0]  dbi,
  output logic        read_enable,
  output logic        write_enable,
  output logic        stack_enable,
  output logic        stack_write,
  output logic        stack_decrement,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [15:0] op_addr,
  input  logic [7:0]  op_data,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic        op_ready,
  output logic        instr_valid,
  output logic [7:0]  instr,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic        load_valid,
  output logic [7:0]  load_data,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FWAIT      = 3'd1,
    ISSUE_DONE = 3'd2,
    EXEC       = 3'd3,
    MWAIT      = 3'd4
  } state_e;

  localparam logic [2:0] c_op_load  = 3'd1;
  localparam logic [2:0] c_op_store = 3'd2;
  localparam logic [2:0] c_op_push  = 3'd3;
  localparam logic [2:0] c_op_pop   = 3'd4;
  // Read data is sampled on the last wait cycle; MWAIT holds one extra cycle
  // so load_valid is presented before the next fetch begins.
  localparam logic [1:0] c_lat_last = 2'(READ_LATENCY - 1);
  localparam logic [1:0] c_lat_done = 2'(READ_LATENCY);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] npc_q, npc_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  data1_q, data1_d;
  logic [7:0]  data2_q, data2_d;
  logic [7:0]  load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic [15:0] w_npc;

  assign w_npc = jump ? jump_addr : (pc_q + 16'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      k_q          <= 2'd0;
      cnt_q        <= 2'd0;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC;
      instr_q      <= 8'h00;
      data1_q      <= 8'h00;
      data2_q      <= 8'h00;
      load_data_q  <= 8'h00;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      instr_q      <= instr_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    cnt_d           = cnt_q;
    pc_d            = pc_q;
    npc_d           = npc_q;
    instr_d         = instr_q;
    data1_d         = data1_q;
    data2_d         = data2_q;
    load_data_d     = load_data_q;
    load_valid_d    = 1'b0;
    abi             = 16'h0000;
    dbi             = 8'h00;
    read_enable     = 1'b0;
    write_enable    = 1'b0;
    stack_enable    = 1'b0;
    stack_write     = 1'b0;
    stack_decrement = 1'b0;
    op_ready        = 1'b0;
    instr_valid     = 1'b0;

    case (state_q)
      FETCH: begin
        abi         = pc_q + {14'd0, k_q};
        read_enable = 1'b1;
        cnt_d       = 2'd0;
        state_d     = FWAIT;
      end
      FWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == c_lat_last) begin
          cnt_d = 2'd0;
          case (k_q)
            2'd0:    instr_d = fbo;
            2'd1:    data1_d = fbo;
            default: data2_d = fbo;
          endcase
          if (k_q == 2'd2) begin
            k_d     = 2'd0;
            state_d = ISSUE_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = FETCH;
          end
        end
      end
      ISSUE_DONE: begin
        instr_valid = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        op_ready = 1'b1;
        if (op_valid) begin
          npc_d = w_npc;
          cnt_d = 2'd0;
          case (op)
            c_op_load: begin
              abi         = op_addr;
              read_enable = 1'b1;
              state_d     = MWAIT;
            end
            c_op_store: begin
              abi          = op_addr;
              dbi          = op_data;
              write_enable = 1'b1;
              pc_d         = w_npc;
              state_d      = FETCH;
            end
            c_op_push: begin
              dbi             = op_data;
              stack_enable    = 1'b1;
              write_enable    = 1'b1;
              stack_write     = 1'b1;
              stack_decrement = 1'b1;
              pc_d            = w_npc;
              state_d         = FETCH;
            end
            c_op_pop: begin
              stack_enable = 1'b1;
              read_enable  = 1'b1;
              stack_write  = 1'b1;
              state_d      = MWAIT;
            end
            default: begin
              pc_d    = w_npc;
              state_d = FETCH;
            end
          endcase
        end
      end
      MWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == c_lat_last) begin
          load_data_d  = fbo;
          load_valid_d = 1'b1;
        end
        if (cnt_q == c_lat_done) begin
          cnt_d   = 2'd0;
          pc_d    = npc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Bus strobes are suppressed for the whole time reset is asserted.
    if (rst) begin
      abi             = 16'h0000;
      dbi             = 8'h00;
      read_enable     = 1'b0;
      write_enable    = 1'b0;
      stack_enable    = 1'b0;
      stack_write     = 1'b0;
      stack_decrement = 1'b0;
      op_ready        = 1'b0;
      instr_valid     = 1'b0;
    end
  end

  assign instr      = instr_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign pc         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_sequencer                                                           |
// | Scoreboard bench: core driver, memory/stack model, latency-3 fetch copy.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_sequencer;

  localparam logic [15:0] RST_PC = 16'h8000;
  localparam logic [2:0]  OP_NONE = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2,
                          OP_PUSH = 3'd3, OP_POP = 3'd4;

  logic clk;
  logic rst;
  logic [7:0]  fbo;
  logic [15:0] abi;
  logic [7:0]  dbi;
  logic read_enable, write_enable, stack_enable, stack_write, stack_decrement;
  logic op_valid;
  logic [2:0]  op;
  logic [15:0] op_addr;
  logic [7:0]  op_data;
  logic jump;
  logic [15:0] jump_addr;
  logic op_ready, instr_valid, load_valid;
  logic [7:0]  instr, data1, data2, load_data;
  logic [15:0] pc;

  logic [7:0]  fbo3;
  logic [15:0] abi3;
  logic [7:0]  dbi3;
  logic re3, we3, se3, sw3, sd3, op_ready3, instr_valid3, load_valid3;
  logic [7:0]  instr3, data13, data23, load_data3;
  logic [15:0] pc3;

  int n_checks = 0;
  int n_fail   = 0;
  int n3       = 0;

  logic [39:0] q_instr[$];
  logic [28:0] q_acc[$];
  logic [7:0]  q_load[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_sequencer #(.RESET_PC(RST_PC), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .fbo(fbo), .abi(abi), .dbi(dbi),
    .read_enable(read_enable), .write_enable(write_enable),
    .stack_enable(stack_enable), .stack_write(stack_write),
    .stack_decrement(stack_decrement), .op_valid(op_valid), .op(op),
    .op_addr(op_addr), .op_data(op_data), .jump(jump), .jump_addr(jump_addr),
    .op_ready(op_ready), .instr_valid(instr_valid), .instr(instr),
    .data1(data1), .data2(data2), .load_valid(load_valid),
    .load_data(load_data), .pc(pc)
  );

  mem_sequencer #(.RESET_PC(RST_PC), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .fbo(fbo3), .abi(abi3), .dbi(dbi3),
    .read_enable(re3), .write_enable(we3), .stack_enable(se3),
    .stack_write(sw3), .stack_decrement(sd3), .op_valid(1'b0), .op(3'd0),
    .op_addr(16'h0000), .op_data(8'h00), .jump(1'b0), .jump_addr(16'h0000),
    .op_ready(op_ready3), .instr_valid(instr_valid3), .instr(instr3),
    .data1(data13), .data2(data23), .load_valid(load_valid3),
    .load_data(load_data3), .pc(pc3)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h8000: return 8'hA1;  16'h8001: return 8'hB2;  16'h8002: return 8'hC3;
      16'h8003: return 8'h11;  16'h8004: return 8'h22;  16'h8005: return 8'h33;
      16'h8006: return 8'h44;  16'h8007: return 8'h55;  16'h8008: return 8'h66;
      16'h8009: return 8'h47;  16'h800A: return 8'h48;  16'h800B: return 8'h49;
      16'h800C: return 8'h4A;  16'h800D: return 8'h4B;  16'h800E: return 8'h4C;
      16'h800F: return 8'h4D;  16'h8010: return 8'h4E;  16'h8011: return 8'h4F;
      16'hFFFE: return 8'hD1;  16'hFFFF: return 8'hD2;  16'h0000: return 8'hD3;
      16'h0001: return 8'hE1;  16'h0002: return 8'hE2;  16'h0003: return 8'hE3;
      16'h8100: return 8'hF1;  16'h8101: return 8'hF2;  16'h8102: return 8'hF3;
      default:  return 8'h00;
    endcase
  endfunction

  // Memory side for the latency-1 instance: RAM over the low 1 KiB, ROM elsewhere,
  // stack pointer writes at sp then decrements, pops read sp+1.
  logic [7:0]  ram   [0:1023];
  logic        wflag [0:1023];
  logic [15:0] sp1;
  logic [7:0]  rd1;
  logic [15:0] ma1;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a < 16'd1024 && wflag[a[9:0]]) return ram[a[9:0]];
    return rom_byte(a);
  endfunction

  assign ma1 = stack_enable ? (write_enable ? sp1 : sp1 + 16'd1) : abi;
  assign fbo = rd1;

  always @(posedge clk) begin
    if (rst) begin
      sp1 <= 16'h01FF;
      rd1 <= 8'hEE;
      for (int i = 0; i < 1024; i++) wflag[i] <= 1'b0;
    end else begin
      if (write_enable && ma1 < 16'd1024) begin
        ram[ma1[9:0]]   <= dbi;
        wflag[ma1[9:0]] <= 1'b1;
      end
      rd1 <= read_enable ? mem_rd(ma1) : 8'hEE;
      if (stack_write) sp1 <= stack_decrement ? sp1 - 16'd1 : sp1 + 16'd1;
    end
  end

  logic [7:0] s3a, s3b, s3c;
  always @(posedge clk) begin
    s3a <= re3 ? rom_byte(abi3) : 8'hEE;
    s3b <= s3a;
    s3c <= s3b;
  end
  assign fbo3 = s3c;

  function automatic logic [28:0] acc(input logic re, input logic we, input logic se,
                                      input logic sw, input logic sd,
                                      input logic [15:0] a, input logic [7:0] d);
    return {re, we, se, sw, sd, (se ? 16'h0000 : a), (we ? d : 8'h00)};
  endfunction

  initial begin : mon_main
    logic [28:0] obs;
    forever begin
      @(negedge clk);
      if (read_enable || write_enable || stack_enable || stack_write) begin
        obs = acc(read_enable, write_enable, stack_enable, stack_write,
                  stack_decrement, abi, dbi);
        if (q_acc.size() == 0) check_val("acc_unexpected", 64'(obs), 64'h0);
        else                   check_val("access", 64'(obs), 64'(q_acc.pop_front()));
      end
      if (instr_valid) begin
        if (q_instr.size() == 0) check_val("instr_unexpected", 64'(instr_valid), 64'h0);
        else check_val("instr", 64'({pc, instr, data1, data2}), 64'(q_instr.pop_front()));
      end
      if (load_valid) begin
        if (q_load.size() == 0) check_val("load_unexpected", 64'(load_valid), 64'h0);
        else check_val("load_data", 64'(load_data), 64'(q_load.pop_front()));
      end
    end
  end

  initial begin : mon_lat3
    int cyc, last3, idx3;
    cyc = 0; last3 = 0; idx3 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) idx3 = 0;
      if (re3 || we3) begin
        check_val("f3_excl", 64'({re3, we3}), 64'h2);
        check_val("f3_addr", 64'(abi3), 64'(RST_PC + 16'(idx3)));
        if (idx3 > 0) check_val("f3_gap", 64'(cyc - last3), 64'd4);
        last3 = cyc;
        idx3++;
      end
      if (instr_valid3) begin
        check_val("f3_instr", 64'({instr3, data13, data23}), 64'h00A1B2C3);
        n3++;
        idx3 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ipc, input logic [23:0] bytes,
                           input logic [2:0] iop, input logic [15:0] addr,
                           input logic [7:0] data, input logic jmp,
                           input logic [15:0] jaddr, input logic [7:0] exp_ld,
                           input int delay, input bit do_op, input bit ghost,
                           input bit rst_in_wait);
    bit seen;
    q_instr.push_back({ipc, bytes});
    for (int k = 0; k < 3; k++)
      q_acc.push_back(acc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ipc + 16'(k), 8'h00));
    if (do_op) begin
      case (iop)
        OP_LOAD: begin
          q_acc.push_back(acc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, addr, 8'h00));
          if (!rst_in_wait) q_load.push_back(exp_ld);
        end
        OP_STORE: q_acc.push_back(acc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, addr, data));
        OP_PUSH:  q_acc.push_back(acc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0, data));
        OP_POP: begin
          q_acc.push_back(acc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 8'h00));
          q_load.push_back(exp_ld);
        end
        default: ;
      endcase
    end
    // A store offered while the sequencer is busy must not reach the bus.
    if (ghost) begin
      op = OP_STORE; op_addr = 16'h0099; op_data = 8'hFF; op_valid = 1'b1;
      repeat (3) step();
      op_valid = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    check_val("instr_seen", 64'(seen), 64'h1);
    if (!do_op) return;
    step();
    repeat (delay) step();
    op = iop; op_addr = addr; op_data = data; jump = jmp; jump_addr = jaddr;
    op_valid = 1'b1;
    check_val("op_ready_hi", 64'(op_ready), 64'h1);
    step();
    op_valid = 1'b0;
    jump = 1'b0;
    check_val("op_ready_lo", 64'(op_ready), 64'h0);
    if (rst_in_wait) begin
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mwait_out", 64'({read_enable, write_enable, stack_enable, stack_write,
                                     load_valid, instr_valid, op_ready}), 64'h0);
      step();
      check_val("rst_mwait_pc", 64'(pc), 64'(RST_PC));
      check_val("rst_mwait_lv", 64'(load_valid), 64'h0);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NONE; op_addr = 16'h0; op_data = 8'h0;
    jump = 1'b0; jump_addr = 16'h0;
    repeat (3) step();
    @(negedge clk);
    check_val("rst_pc", 64'(pc), 64'(RST_PC));
    check_val("rst_ctrl", 64'({read_enable, write_enable, stack_enable, stack_write,
                               stack_decrement, op_ready, instr_valid, load_valid}), 64'h0);
    check_val("rst_data", 64'({abi, dbi, instr, data1, data2, load_data}), 64'h0);
    step();
    rst = 1'b0;

    //        pc        bytes       op        addr      data  jmp  jaddr     ld     dly op gh rw
    run_instr(16'h8000, 24'hA1B2C3, OP_STORE, 16'h0010, 8'h5A, 1'b0, 16'h0000, 8'h00, 0, 1, 0, 0);
    run_instr(16'h8003, 24'h112233, OP_LOAD,  16'h0010, 8'h00, 1'b0, 16'h0000, 8'h5A, 0, 1, 0, 0);
    run_instr(16'h8006, 24'h445566, OP_PUSH,  16'h0000, 8'h77, 1'b0, 16'h0000, 8'h00, 0, 1, 1, 0);
    check_val("ld_hold", 64'(load_data), 64'h5A);
    run_instr(16'h8009, 24'h474849, OP_PUSH,  16'h0000, 8'h88, 1'b0, 16'h0000, 8'h00, 3, 1, 0, 0);
    run_instr(16'h800C, 24'h4A4B4C, OP_POP,   16'h0000, 8'h00, 1'b0, 16'h0000, 8'h88, 0, 1, 0, 0);
    run_instr(16'h800F, 24'h4D4E4F, OP_POP,   16'h0000, 8'h00, 1'b1, 16'hFFFE, 8'h77, 0, 1, 0, 0);
    run_instr(16'hFFFE, 24'hD1D2D3, OP_NONE,  16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 0, 1, 0, 0);
    run_instr(16'h0001, 24'hE1E2E3, OP_NONE,  16'h0000, 8'h00, 1'b1, 16'h8100, 8'h00, 0, 1, 0, 0);
    run_instr(16'h8100, 24'hF1F2F3, OP_LOAD,  16'h0020, 8'h00, 1'b0, 16'h0000, 8'h00, 0, 1, 0, 1);
    run_instr(16'h8000, 24'hA1B2C3, OP_NONE,  16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 0, 0, 0, 0);

    repeat (20) @(negedge clk);
    check_val("q_instr_left", 64'(q_instr.size()), 64'h0);
    check_val("q_acc_left", 64'(q_acc.size()), 64'h0);
    check_val("q_load_left", 64'(q_load.size()), 64'h0);
    check_val("f3_instr_count", 64'(n3), 64'd2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- CPU-side bus initiator for the load/store unit.
- Drives the address, write-data, enable and stack-control strobes into the memory side, and captures read data from its byte output.
- Fetches each 3-byte instruction (opcode, data1, data2) from the program counter, hands it to the core, then performs one load, store, push or pop per instruction.
- All memory accesses are issued strictly one at a time.

Parameters:
RESET_PC, 16'h8000, program counter value after reset (start of ROM region).
READ_LATENCY, 1, clock cycles from a read strobe to valid fbo data (legal range 1..3).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  synchronous reset, active-high.
fbo  input  8  read data returned by the memory side.
abi  output  16  memory address.
dbi  output  8  memory write data.
read_enable  output  1  memory read strobe.
write_enable  output  1  memory write strobe.
stack_enable  output  1  memory access is addressed by the stack pointer.
stack_write  output  1  update the stack pointer this cycle.
stack_decrement  output  1  direction of the stack pointer update: 1 = decrement, 0 = increment.
op_valid  input  1  core presents an operation for the current instruction.
op  input  3  0 NONE, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; 5-7 are treated as NONE.
op_addr  input  16  LOAD/STORE address.
op_data  input  8  STORE/PUSH data.
jump  input  1  at op acceptance: next pc is jump_addr instead of pc+3.
jump_addr  input  16  branch target.
op_ready  output  1  sequencer will accept op this cycle.
instr_valid  output  1  one-cycle pulse; instr/data1/data2 are newly valid.
instr  output  8  fetched opcode byte.
data1  output  8  fetched byte at pc+1.
data2  output  8  fetched byte at pc+2.
load_valid  output  1  one-cycle pulse; load_data is newly valid.
load_data  output  8  result of LOAD/POP.
pc  output  16  address of the current instruction.

Behaviour:
- Reset (checked before all other logic, any state):
  - pc = RESET_PC; state = FETCH.
  - All strobes, op_ready, instr_valid and load_valid = 0.
  - abi, dbi, instr, data1, data2 and load_data = 0.
  - An access in flight is abandoned and its late data is ignored.
- States: FETCH, FWAIT, ISSUE_DONE, EXEC, MWAIT.
- FETCH / FWAIT (byte index k = 0,1,2):
  - FETCH: abi = pc+k (16-bit wrap, FFFF+1 = 0000), read_enable = 1 for exactly one cycle; go to FWAIT.
  - FWAIT: count READ_LATENCY cycles, sample fbo into byte k.
  - If k < 2, go back to FETCH with k+1.
  - After byte 2, go to ISSUE_DONE.
- ISSUE_DONE: instr_valid = 1 for one cycle; go to EXEC.
- EXEC: op_ready = 1. The op is accepted on the cycle op_valid && op_ready; op_ready drops the next cycle. On acceptance:
  - NONE: no strobes; update pc; go to FETCH.
  - STORE: one cycle with abi = op_addr, dbi = op_data, write_enable = 1; update pc; go to FETCH.
  - LOAD: one cycle with abi = op_addr, read_enable = 1; go to MWAIT.
  - PUSH: one cycle with stack_enable = 1, write_enable = 1, dbi = op_data, stack_write = 1, stack_decrement = 1; update pc; go to FETCH.
  - POP: one cycle with stack_enable = 1, read_enable = 1, stack_write = 1, stack_decrement = 0; go to MWAIT.
- MWAIT: after READ_LATENCY cycles, capture fbo into load_data and pulse load_valid for one cycle that same cycle; update pc; go to FETCH.
- Strobe exclusivity: read_enable and write_enable are never high together. Every strobe lasts exactly one cycle. All strobes are 0 in wait states.
- pc update: if jump was high at acceptance, pc = jump_addr (latched at acceptance); otherwise pc = pc+3, mod 2^16.
- Edge cases:
  - op_valid outside EXEC is ignored.
  - EXEC waits indefinitely for op_valid.
  - instr/data1/data2 hold their values until the next instr_valid.
  - load_data holds its value until the next load_valid.
- Instruction-to-instruction timing: minimum cycles from one instr_valid to the next = 3*(1+READ_LATENCY) + 2 for NONE/STORE/PUSH; add READ_LATENCY+1 for LOAD/POP.

Test Plan:
- Fetch: release rst; ROM holds 8000:A1, 8001:B2, 8002:C3 -> reads at 8000, 8001, 8002, one read_enable each; instr_valid with instr = A1, data1 = B2, data2 = C3; pc = 8000.
- Store/load round trip: STORE op_addr = 0010, op_data = 5A -> one write_enable cycle with abi = 0010, dbi = 5A; next instruction LOAD 0010 -> load_valid with load_data = 5A; pc advances 8000 -> 8003 -> 8006.
- Stack: PUSH 77, then PUSH 88, then POP, then POP -> stack_decrement = 1 on both pushes, 0 on both pops; load_data = 88, then 77.
- Wrap and jump: pc = FFFE -> fetch addresses FFFE, FFFF, 0000, next pc = 0001; op NONE with jump = 1, jump_addr = 8100 -> next fetch at 8100.
- Reset mid-operation: assert rst during the MWAIT of a LOAD -> next cycle all strobes 0, no load_valid; the following fetch starts at 8000.
- Latency: rerun the fetch test with READ_LATENCY = 3 -> same bytes captured; strobes 4 cycles apart; read_enable and write_enable never high together throughout.
